// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle logic/arith/shift ops plus iterative signed
// Booth multiply and restoring divide sharing one accumulator/quotient datapath.
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic             start,
    input  logic [4:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] z_low,
    output logic [WIDTH-1:0] z_high,
    output logic             div_zero,
    output logic             illegal,
    output logic [1:0]       dbg_state
);

    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_SHR = 5'b00101;
    localparam logic [4:0] OP_SHL = 5'b00110;
    localparam logic [4:0] OP_ROR = 5'b00111;
    localparam logic [4:0] OP_ROL = 5'b01000;
    localparam logic [4:0] OP_AND = 5'b01001;
    localparam logic [4:0] OP_OR  = 5'b01010;
    localparam logic [4:0] OP_MUL = 5'b01110;
    localparam logic [4:0] OP_DIV = 5'b01111;
    localparam logic [4:0] OP_NEG = 5'b10000;
    localparam logic [4:0] OP_NOT = 5'b10001;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MUL_RUN = 2'd1,
        DIV_RUN = 2'd2,
        FINISH  = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH:0]   acc_q, acc_d;   // Booth partial product / divide remainder
    logic [WIDTH-1:0] q_q, q_d;       // multiplier bits / dividend-then-quotient
    logic [WIDTH:0]   m_q, m_d;       // sign-extended multiplicand / |divisor|
    logic             qm1_q, qm1_d;
    logic             is_div_q, is_div_d;
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0] zl_q, zl_d, zh_q, zh_d;
    logic             done_q, done_d, dz_q, dz_d, ill_q, ill_d;

    // Single-cycle result path, evaluated straight from the live inputs.
    logic [SHW-1:0]     sh_amt;
    logic [2*WIDTH-1:0] rot;
    logic [WIDTH-1:0]   sc_lo, sc_hi;
    logic               sc_dz, sc_ill;

    assign sh_amt = b[SHW-1:0];

    always_comb begin
        sc_lo  = '0;
        sc_dz  = 1'b0;
        sc_ill = 1'b0;
        rot    = '0;
        case (opcode)
            OP_ADD: sc_lo = a + b;
            OP_SUB: sc_lo = a - b;
            OP_SHR: sc_lo = a >> sh_amt;
            OP_SHL: sc_lo = a << sh_amt;
            OP_ROR: begin
                rot   = {a, a} >> sh_amt;
                sc_lo = rot[WIDTH-1:0];
            end
            OP_ROL: begin
                rot   = {a, a} << sh_amt;
                sc_lo = rot[2*WIDTH-1:WIDTH];
            end
            OP_AND: sc_lo = a & b;
            OP_OR:  sc_lo = a | b;
            OP_NEG: sc_lo = -b;
            OP_NOT: sc_lo = ~b;
            OP_MUL: sc_lo = '0;
            OP_DIV: begin
                // Only reached with b==0; nonzero divisors take the iterative path.
                sc_lo = '1;
                sc_dz = 1'b1;
            end
            default: sc_ill = 1'b1;
        endcase
    end

    assign sc_hi = (opcode == OP_DIV) ? a : {WIDTH{sc_lo[WIDTH-1]}};

    logic [WIDTH-1:0] a_abs, b_abs;
    assign a_abs = a[WIDTH-1] ? -a : a;
    assign b_abs = b[WIDTH-1] ? -b : b;

    logic [WIDTH:0] booth_sum, rem_sh, rem_diff;

    always_comb begin
        case ({q_q[0], qm1_q})
            2'b01:   booth_sum = acc_q + m_q;
            2'b10:   booth_sum = acc_q - m_q;
            default: booth_sum = acc_q;
        endcase
        rem_sh   = {acc_q[WIDTH-1:0], q_q[WIDTH-1]};
        rem_diff = rem_sh - m_q;
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        q_d       = q_q;
        m_d       = m_q;
        qm1_d     = qm1_q;
        is_div_d  = is_div_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        zl_d      = zl_q;
        zh_d      = zh_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
        ill_d     = ill_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    dz_d  = 1'b0;
                    ill_d = 1'b0;
                    if (opcode == OP_MUL) begin
                        acc_d    = '0;
                        q_d      = b;
                        m_d      = {a[WIDTH-1], a};
                        qm1_d    = 1'b0;
                        is_div_d = 1'b0;
                        cnt_d    = SHW'(WIDTH - 1);
                        state_d  = MUL_RUN;
                    end else if (opcode == OP_DIV && b != '0) begin
                        acc_d     = '0;
                        q_d       = a_abs;
                        m_d       = {1'b0, b_abs};
                        is_div_d  = 1'b1;
                        neg_quo_d = a[WIDTH-1] ^ b[WIDTH-1];
                        neg_rem_d = a[WIDTH-1];
                        cnt_d     = SHW'(WIDTH - 1);
                        state_d   = DIV_RUN;
                    end else begin
                        zl_d   = sc_lo;
                        zh_d   = sc_hi;
                        dz_d   = sc_dz;
                        ill_d  = sc_ill;
                        done_d = 1'b1;
                    end
                end
            end
            MUL_RUN: begin
                acc_d = {booth_sum[WIDTH], booth_sum[WIDTH:1]};
                q_d   = {booth_sum[0], q_q[WIDTH-1:1]};
                qm1_d = q_q[0];
                if (cnt_q == '0) state_d = FINISH;
                else             cnt_d   = cnt_q - SHW'(1);
            end
            DIV_RUN: begin
                acc_d = rem_diff[WIDTH] ? rem_sh : rem_diff;
                q_d   = {q_q[WIDTH-2:0], ~rem_diff[WIDTH]};
                if (cnt_q == '0) state_d = FINISH;
                else             cnt_d   = cnt_q - SHW'(1);
            end
            FINISH: begin
                if (is_div_q) begin
                    zl_d = neg_quo_q ? -q_q : q_q;
                    zh_d = neg_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                end else begin
                    zl_d = q_q;
                    zh_d = acc_q[WIDTH-1:0];
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            m_q       <= '0;
            qm1_q     <= 1'b0;
            is_div_q  <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            zl_q      <= '0;
            zh_q      <= '0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
            ill_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            m_q       <= m_d;
            qm1_q     <= qm1_d;
            is_div_q  <= is_div_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            zl_q      <= zl_d;
            zh_q      <= zh_d;
            done_q    <= done_d;
            dz_q      <= dz_d;
            ill_q     <= ill_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = done_q;
    assign z_low     = zl_q;
    assign z_high    = zh_q;
    assign div_zero  = dz_q;
    assign illegal   = ill_q;
    assign dbg_state = state_q;

endmodule
